mem_arbiter: RTL

- Shares the single-port on-chip RAM between two bus masters: m0 (cpu) and m1 (loader/DMA port).
- Masters use the CPU-style bus: ren/wen, addr, wdata, wr_mask, rdata, rd_valid, plus a per-master ack.
- Arbitration is round-robin, with one read in flight at a time. Read data returns after a fixed RAM latency and is routed to the master that issued the read.
- Sits between the cpu and ram modules in the top level.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter.
//   - arb_state_t : arbiter FSM states (arbitrate / wait for read data)
//   - MID_CPU     : master id of the cpu port (m0)
//   - MID_AUX     : master id of the loader/DMA port (m1)
//   - CNT_W       : width of the read-latency down-counter (RD_LAT up to 4)
package mem_arbiter_pkg;

   typedef enum logic {
      ST_ARB_IDLE   = 1'b0,
      ST_ARB_RDWAIT = 1'b1
   } arb_state_t;

   localparam logic MID_CPU = 1'b0;
   localparam logic MID_AUX = 1'b1;

   localparam int CNT_W = 2;

   // Counter load value so that the counter hits zero RD_LAT cycles after ram_ren.
   function automatic logic [CNT_W-1:0] rd_cnt_init(input int rd_lat);
      return CNT_W'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports:
//   req[1:0]    in  request per master (bit index = master id)
//   last_grant  in  id of the master granted most recently
//   grant[1:0]  out one-hot grant, 0 when nobody requests
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       req_0,
   input  logic       req_1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_0 && req_1) begin
         // Tie: hand the slot to whoever did not have it last time.
         if (last_grant == MID_CPU) begin
            grant[MID_AUX] = 1'b1;
         end else begin
            grant[MID_CPU] = 1'b1;
         end
      end else if (req_0) begin
         grant[MID_CPU] = 1'b1;
      end else if (req_1) begin
         grant[MID_AUX] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the cpu (m0) and the loader/DMA port (m1).
// Round-robin arbitration; one read in flight at a time; read data is routed
// to the master that issued the read after a fixed RAM latency.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mX_ren/mX_wen                 read / write request, held until mX_ack
//   mX_addr/mX_wdata/mX_wr_mask   request payload
//   mX_ack                        request accepted this cycle (combinational)
//   mX_rdata/mX_rd_valid          read data (shared) and per-master valid pulse
//   ram_*                         RAM side strobes, address, data, byte enables
//   ram_rdata                     RAM read data, valid RD_LAT cycles after ram_ren
//   proto_err                     sticky: a granted master raised ren and wen together
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int RD_LAT  = 1,
   parameter int WP_ZERO = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_ren,
   input  logic            m0_wen,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_wr_mask,
   output logic            m0_ack,
   output logic [DW-1:0]   m0_rdata,
   output logic            m0_rd_valid,
   input  logic            m1_ren,
   input  logic            m1_wen,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wr_mask,
   output logic            m1_ack,
   output logic [DW-1:0]   m1_rdata,
   output logic            m1_rd_valid,
   output logic            ram_ren,
   output logic            ram_wen,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_wdata,
   output logic [DW/8-1:0] ram_wr_mask,
   input  logic [DW-1:0]   ram_rdata,
   output logic            proto_err
);

   localparam logic [CNT_W-1:0] CNT_INIT = rd_cnt_init(RD_LAT);

   arb_state_t        state_reg;
   logic              last_grant_reg;
   logic              rd_owner_reg;
   logic              proto_err_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              arb_open;
   logic [1:0]        grant;
   logic              gnt_any;
   logic              sel;
   logic              g_ren;
   logic              g_wen;
   logic [AW-1:0]     g_addr;
   logic [DW-1:0]     g_wdata;
   logic [DW/8-1:0]   g_mask;
   logic              wr_go;
   logic              rd_go;
   logic              wr_blocked;
   logic              rd_fire;
   logic [1:0]        rd_valid_vec;

   // Requests are only considered while arbitrating and out of reset, so
   // nothing is acked or strobed during rst or while a read is outstanding.
   assign arb_open = (state_reg == ST_ARB_IDLE) && !rst;

   rr_arb2 u_rr_arb2 (
      .req_0      (arb_open && (m0_ren || m0_wen)),
      .req_1      (arb_open && (m1_ren || m1_wen)),
      .last_grant (last_grant_reg),
      .grant      (grant)
   );

   assign gnt_any = |grant;
   assign sel     = grant[MID_AUX];

   assign g_ren   = sel ? m1_ren     : m0_ren;
   assign g_wen   = sel ? m1_wen     : m0_wen;
   assign g_addr  = sel ? m1_addr    : m0_addr;
   assign g_wdata = sel ? m1_wdata   : m0_wdata;
   assign g_mask  = sel ? m1_wr_mask : m0_wr_mask;

   // ren+wen together counts as a write; the read half is dropped.
   assign wr_go      = gnt_any && g_wen;
   assign rd_go      = gnt_any && g_ren && !g_wen;
   assign wr_blocked = (WP_ZERO != 0) && (g_addr == '0);

   assign ram_wen     = wr_go && !wr_blocked;
   assign ram_ren     = rd_go;
   assign ram_addr    = gnt_any ? g_addr  : '0;
   assign ram_wdata   = gnt_any ? g_wdata : '0;
   assign ram_wr_mask = gnt_any ? g_mask  : '0;

   assign m0_ack = grant[MID_CPU];
   assign m1_ack = grant[MID_AUX];

   // Both masters see the RAM data; only the owner's valid pulses.
   assign m0_rdata = ram_rdata;
   assign m1_rdata = ram_rdata;

   assign rd_fire = (state_reg == ST_ARB_RDWAIT) && (cnt_reg == '0) && !rst;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd_valid
      assign rd_valid_vec[gi] = rd_fire && (rd_owner_reg == 1'(gi));
   end

   assign m0_rd_valid = rd_valid_vec[MID_CPU];
   assign m1_rd_valid = rd_valid_vec[MID_AUX];

   assign proto_err = proto_err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_ARB_IDLE;
         last_grant_reg <= MID_AUX;
         rd_owner_reg   <= MID_CPU;
         cnt_reg        <= '0;
         proto_err_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_ARB_IDLE: begin
               if (gnt_any) begin
                  last_grant_reg <= sel;
                  if (g_ren && g_wen) begin
                     proto_err_reg <= 1'b1;
                  end
                  if (rd_go) begin
                     rd_owner_reg <= sel;
                     cnt_reg      <= CNT_INIT;
                     state_reg    <= ST_ARB_RDWAIT;
                  end
               end
            end
            ST_ARB_RDWAIT: begin
               // The valid pulse is issued in the cycle the counter is zero;
               // arbitration resumes the cycle after.
               if (cnt_reg == '0) begin
                  state_reg <= ST_ARB_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
         endcase
      end
   end

endmodule
